// File: rtl/tof_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tof_sweep_scheduler
// Purpose  : Schedules DAC configuration sweeps and rate-timed monitoring
//            sweeps onto one shared I2C transaction engine (single clock).
// Ports    : clk_i/rst_i             clock, synchronous active-high reset
//            ready_o                 idle with nothing pending
//            update_i                request a config sweep (pulse)
//            update_complete_o       one-cycle pulse at end of config sweep
//            mon_rate_i              rate ticks between monitor sweeps (0=off)
//            cfg_addr_o/cfg_dat_i    config register file read port
//            mon_addr_o/mon_dat_o/mon_wr_o  monitor register file write port
//            cmd_*                   command handshake to the I2C engine
//            rsp_*                   response strobe from the I2C engine
//            err_count_o             saturating error/timeout count
// Revision : 1.0 - initial release
// ============================================================================
module tof_sweep_scheduler #(
    parameter int NUM_CFG  = 66,
    parameter int NUM_MON  = 77,
    parameter int TICK_DIV = 200000,
    parameter int TIMEOUT  = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        ready_o,
    input  logic        update_i,
    output logic        update_complete_o,
    input  logic [15:0] mon_rate_i,
    output logic [6:0]  cfg_addr_o,
    input  logic [15:0] cfg_dat_i,
    output logic [6:0]  mon_addr_o,
    output logic [15:0] mon_dat_o,
    output logic        mon_wr_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        cmd_write_o,
    output logic [6:0]  cmd_addr_o,
    output logic [15:0] cmd_dat_o,
    input  logic        rsp_valid_i,
    input  logic [15:0] rsp_dat_i,
    input  logic        rsp_err_i,
    output logic [7:0]  err_count_o
);

    localparam logic [3:0] c_s_idle      = 4'd0;
    localparam logic [3:0] c_s_cfg_fetch = 4'd1;
    localparam logic [3:0] c_s_cfg_cmd   = 4'd2;
    localparam logic [3:0] c_s_cfg_wait  = 4'd3;
    localparam logic [3:0] c_s_mon_cmd   = 4'd4;
    localparam logic [3:0] c_s_mon_wait  = 4'd5;
    localparam logic [3:0] c_s_mon_wr    = 4'd6;
    localparam logic [3:0] c_s_cfg_done  = 4'd7;

    localparam logic [6:0] c_cfg_last = 7'(NUM_CFG - 1);
    localparam logic [6:0] c_mon_last = 7'(NUM_MON - 1);

    localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);

    localparam int c_wait_w = $clog2(TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);

    logic [3:0]           r_state;
    logic [3:0]           w_state_nxt;
    logic [6:0]           r_idx;
    logic [6:0]           r_cfg_addr;
    logic [15:0]          r_cmd_dat;
    logic [15:0]          r_mon_dat;
    logic [7:0]           r_err_cnt;
    logic                 r_upd_pend;
    logic                 r_mon_pend;
    logic [c_presc_w-1:0] r_presc;
    logic [15:0]          r_rate_cnt;
    logic [c_wait_w-1:0]  r_wait_cnt;

    logic w_tick;
    logic w_rate_hit;
    logic w_take_upd;
    logic w_take_mon;
    logic w_in_wait;
    logic w_timeout;
    logic w_rsp_done;
    logic w_rsp_bad;
    logic w_cfg_last;
    logic w_mon_last;

    assign w_tick     = (r_presc == c_presc_last);
    assign w_rate_hit = w_tick && (mon_rate_i != 16'd0) &&
                        (({1'b0, r_rate_cnt} + 17'd1) >= {1'b0, mon_rate_i});
    assign w_take_upd = (r_state == c_s_idle) && r_upd_pend;
    assign w_take_mon = (r_state == c_s_idle) && !r_upd_pend && r_mon_pend;
    assign w_in_wait  = (r_state == c_s_cfg_wait) || (r_state == c_s_mon_wait);
    assign w_timeout  = (r_wait_cnt == c_wait_last);
    assign w_rsp_done = rsp_valid_i || w_timeout;
    // A timeout without any response counts as an errored transaction.
    assign w_rsp_bad  = rsp_valid_i ? rsp_err_i : 1'b1;
    assign w_cfg_last = (r_idx == c_cfg_last);
    assign w_mon_last = (r_idx == c_mon_last);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle: begin
                if (r_upd_pend) begin
                    w_state_nxt = c_s_cfg_fetch;
                end else if (r_mon_pend) begin
                    w_state_nxt = c_s_mon_cmd;
                end
            end
            c_s_cfg_fetch: w_state_nxt = c_s_cfg_cmd;
            c_s_cfg_cmd:   if (cmd_ready_i) w_state_nxt = c_s_cfg_wait;
            c_s_cfg_wait: begin
                if (w_rsp_done) begin
                    w_state_nxt = w_cfg_last ? c_s_cfg_done : c_s_cfg_fetch;
                end
            end
            c_s_cfg_done:  w_state_nxt = c_s_idle;
            c_s_mon_cmd:   if (cmd_ready_i) w_state_nxt = c_s_mon_wait;
            c_s_mon_wait:  if (w_rsp_done) w_state_nxt = c_s_mon_wr;
            c_s_mon_wr:    w_state_nxt = w_mon_last ? c_s_idle : c_s_mon_cmd;
            default:       w_state_nxt = c_s_idle;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        ready_o           = (r_state == c_s_idle) && !r_upd_pend && !r_mon_pend;
        update_complete_o = (r_state == c_s_cfg_done);
        cmd_valid_o       = (r_state == c_s_cfg_cmd) || (r_state == c_s_mon_cmd);
        cmd_write_o       = (r_state == c_s_cfg_cmd);
        mon_wr_o          = (r_state == c_s_mon_wr);
        cmd_addr_o        = r_idx;
        mon_addr_o        = r_idx;
        cmd_dat_o         = r_cmd_dat;
        mon_dat_o         = r_mon_dat;
        cfg_addr_o        = r_cfg_addr;
        err_count_o       = r_err_cnt;
    end

    // ---------------- datapath, pending flags, timers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx      <= 7'd0;
            r_cfg_addr <= 7'd0;
            r_cmd_dat  <= 16'd0;
            r_mon_dat  <= 16'd0;
            r_err_cnt  <= 8'd0;
            r_upd_pend <= 1'b0;
            r_mon_pend <= 1'b0;
            r_presc    <= '0;
            r_rate_cnt <= 16'd0;
            r_wait_cnt <= '0;
        end else begin
            // A new request on the take cycle must survive, so set wins.
            if (update_i) begin
                r_upd_pend <= 1'b1;
            end else if (w_take_upd) begin
                r_upd_pend <= 1'b0;
            end

            if (w_rate_hit) begin
                r_mon_pend <= 1'b1;
            end else if (w_take_mon) begin
                r_mon_pend <= 1'b0;
            end

            r_presc <= w_tick ? '0 : r_presc + 1'b1;

            if (mon_rate_i == 16'd0) begin
                r_rate_cnt <= 16'd0;
            end else if (w_tick) begin
                r_rate_cnt <= w_rate_hit ? 16'd0 : r_rate_cnt + 16'd1;
            end

            // Cleared while the command is offered, so counting begins at acceptance.
            r_wait_cnt <= w_in_wait ? r_wait_cnt + 1'b1 : '0;

            if (w_in_wait && w_rsp_done && w_rsp_bad && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            case (r_state)
                c_s_idle: begin
                    if (w_take_upd || w_take_mon) begin
                        r_idx <= 7'd0;
                    end
                end
                c_s_cfg_fetch: r_cmd_dat <= cfg_dat_i;
                c_s_cfg_cmd: begin
                    // Present the next read address early so the file's
                    // one-cycle read latency is hidden behind the wait.
                    if (cmd_ready_i) begin
                        r_cfg_addr <= w_cfg_last ? 7'd0 : r_idx + 7'd1;
                    end
                end
                c_s_cfg_wait: begin
                    if (w_rsp_done && !w_cfg_last) begin
                        r_idx <= r_idx + 7'd1;
                    end
                end
                c_s_cfg_done:  r_idx <= 7'd0;
                c_s_mon_wait: begin
                    if (w_rsp_done) begin
                        r_mon_dat <= w_rsp_bad ? 16'hFFFF : rsp_dat_i;
                    end
                end
                c_s_mon_wr: r_idx <= w_mon_last ? 7'd0 : r_idx + 7'd1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tof_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tof_sweep_scheduler
// Purpose  : Self-checking bench for tof_sweep_scheduler with an I2C engine
//            model, a config register file model and scoreboards for the
//            command stream and monitor writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tof_sweep_scheduler;

    localparam int NUM_CFG  = 66;
    localparam int NUM_MON  = 77;
    localparam int TICK_DIV = 10;
    localparam int TIMEOUT  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready_o;
    logic        update_i;
    logic        update_complete_o;
    logic [15:0] mon_rate_i;
    logic [6:0]  cfg_addr_o;
    logic [15:0] cfg_dat_i;
    logic [6:0]  mon_addr_o;
    logic [15:0] mon_dat_o;
    logic        mon_wr_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic        cmd_write_o;
    logic [6:0]  cmd_addr_o;
    logic [15:0] cmd_dat_o;
    logic        rsp_valid_i;
    logic [15:0] rsp_dat_i;
    logic        rsp_err_i;
    logic [7:0]  err_count_o;

    tof_sweep_scheduler #(
        .NUM_CFG  (NUM_CFG),
        .NUM_MON  (NUM_MON),
        .TICK_DIV (TICK_DIV),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ready_o           (ready_o),
        .update_i          (update_i),
        .update_complete_o (update_complete_o),
        .mon_rate_i        (mon_rate_i),
        .cfg_addr_o        (cfg_addr_o),
        .cfg_dat_i         (cfg_dat_i),
        .mon_addr_o        (mon_addr_o),
        .mon_dat_o         (mon_dat_o),
        .mon_wr_o          (mon_wr_o),
        .cmd_valid_o       (cmd_valid_o),
        .cmd_ready_i       (cmd_ready_i),
        .cmd_write_o       (cmd_write_o),
        .cmd_addr_o        (cmd_addr_o),
        .cmd_dat_o         (cmd_dat_o),
        .rsp_valid_i       (rsp_valid_i),
        .rsp_dat_i         (rsp_dat_i),
        .rsp_err_i         (rsp_err_i),
        .err_count_o       (err_count_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboards: {addr[6:0], data[15:0]}
    logic [22:0] q_cmd[$];
    logic [22:0] q_mon[$];

    logic [15:0] cfg_mem [0:127];

    int  stall_left  = 0;
    int  drop_idx    = -1;
    bit  inj_err     = 1'b0;
    int  cfg_acc     = 0;
    int  mon_wr_total = 0;
    int  cpl_cnt     = 0;
    int  exp_err     = 0;
    int  raw_err     = 0;
    int  exp_mon_idx = 0;
    int  t_drop_acc  = -1;
    bit  seen_drop   = 1'b0;
    bit  cfg40_hit   = 1'b0;

    // Config register file: synchronous read, data one cycle after address.
    initial begin
        logic [6:0] a;
        for (int i = 0; i < 128; i++) cfg_mem[i] = 16'(16'hA5C3 ^ (i * 16'h0137));
        cfg_dat_i = 16'd0;
        forever begin
            @(negedge clk);
            a = cfg_addr_o;
            @(posedge clk);
            #1;
            cfg_dat_i = cfg_mem[a];
        end
    end

    // I2C engine model: accepts a command, responds two cycles later.
    initial begin
        int          rsp_cnt;
        logic [6:0]  pend_addr;
        logic        pend_write;
        logic        pend_drop;
        logic        pend_err;
        logic [22:0] e;
        rsp_cnt = 0;
        pend_addr = '0; pend_write = 1'b0; pend_drop = 1'b0; pend_err = 1'b0;
        cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_err_i = 1'b0; rsp_dat_i = 16'd0;
        forever begin
            @(negedge clk);
            rsp_valid_i = 1'b0;
            rsp_err_i   = 1'b0;
            if (rst) begin
                cmd_ready_i = 1'b0;
                rsp_cnt     = 0;
            end else begin
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0 && !pend_drop) begin
                        rsp_valid_i = 1'b1;
                        rsp_dat_i   = pend_write ? 16'hDEAD : 16'h1000 + 16'(pend_addr);
                        rsp_err_i   = pend_err;
                    end
                end
                if (cmd_ready_i) begin
                    cmd_ready_i = 1'b0;
                    rsp_cnt     = 2;
                    if (pend_write && pend_addr == 7'd40) cfg40_hit = 1'b1;
                end else if (stall_left > 0 && cfg_acc == 5 && (stall_left < 50 || cmd_valid_o)) begin
                    check("stall_valid", cmd_valid_o, 1);
                    check("stall_write", cmd_write_o, 1);
                    check("stall_addr", cmd_addr_o, 5);
                    check("stall_dat", cmd_dat_o, cfg_mem[5]);
                    stall_left--;
                end else if (cmd_valid_o) begin
                    cmd_ready_i = 1'b1;
                    pend_addr   = cmd_addr_o;
                    pend_write  = cmd_write_o;
                    pend_drop   = 1'b0;
                    pend_err    = 1'b0;
                    if (cmd_write_o) begin
                        check("cfg_atomic", mon_wr_total % NUM_MON, 0);
                        check("cfg_q_nonempty", q_cmd.size() > 0, 1);
                        if (q_cmd.size() > 0) begin
                            e = q_cmd.pop_front();
                            check("cfg_cmd_addr", cmd_addr_o, e[22:16]);
                            check("cfg_cmd_dat", cmd_dat_o, e[15:0]);
                        end
                        cfg_acc++;
                    end else begin
                        check("mon_atomic", cfg_acc % NUM_CFG, 0);
                        check("mon_cmd_addr", cmd_addr_o, exp_mon_idx);
                        exp_mon_idx = (exp_mon_idx + 1) % NUM_MON;
                        pend_drop = (int'(cmd_addr_o) == drop_idx);
                        pend_err  = inj_err;
                        if (pend_drop || pend_err) begin
                            raw_err++;
                            if (exp_err < 255) exp_err++;
                        end
                        q_mon.push_back({cmd_addr_o,
                                         (pend_drop || pend_err) ? 16'hFFFF : 16'h1000 + 16'(cmd_addr_o)});
                        if (pend_drop) t_drop_acc = cyc;
                    end
                end
            end
        end
    end

    // Output monitor: completion pulses and monitor register file writes.
    initial begin
        logic [22:0] e;
        forever begin
            @(negedge clk);
            if (update_complete_o) cpl_cnt++;
            if (mon_wr_o) begin
                mon_wr_total++;
                check("mon_q_nonempty", q_mon.size() > 0, 1);
                if (q_mon.size() > 0) begin
                    e = q_mon.pop_front();
                    check("mon_wr_addr", mon_addr_o, e[22:16]);
                    check("mon_wr_dat", mon_dat_o, e[15:0]);
                end
                check("err_count", err_count_o, exp_err);
                if (t_drop_acc >= 0 && int'(mon_addr_o) == drop_idx) begin
                    check("timeout_latency", cyc - t_drop_acc, TIMEOUT + 1);
                    t_drop_acc = -1;
                    seen_drop  = 1'b1;
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, ready_o, 1);
        check({tag, "_cmd_valid"}, cmd_valid_o, 0);
        check({tag, "_cmd_write"}, cmd_write_o, 0);
        check({tag, "_cmd_addr"}, cmd_addr_o, 0);
        check({tag, "_cmd_dat"}, cmd_dat_o, 0);
        check({tag, "_cfg_addr"}, cfg_addr_o, 0);
        check({tag, "_mon_wr"}, mon_wr_o, 0);
        check({tag, "_mon_addr"}, mon_addr_o, 0);
        check({tag, "_mon_dat"}, mon_dat_o, 0);
        check({tag, "_complete"}, update_complete_o, 0);
        check({tag, "_err_count"}, err_count_o, 0);
    endtask

    task automatic push_cfg_sweep();
        for (int i = 0; i < NUM_CFG; i++) q_cmd.push_back({7'(i), cfg_mem[i]});
    endtask

    task automatic pulse_update();
        update_i = 1'b1;
        @(negedge clk);
        update_i = 1'b0;
    endtask

    task automatic wait_cpl(input int target, input int budget, input string tag);
        int t;
        t = 0;
        while (cpl_cnt < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, cpl_cnt, target);
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int t;
        t = 0;
        while (!ready_o && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, ready_o, 1);
    endtask

    // Global watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t;
        int busy;
        int cpl_before;
        rst        = 1'b1;
        update_i   = 1'b0;
        mon_rate_i = 16'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Config sweep with a 50-cycle stall on index 5.
        push_cfg_sweep();
        stall_left = 50;
        update_i = 1'b1;
        @(negedge clk);
        update_i = 1'b0;
        lat = 1;
        check("ready_while_pending", ready_o, 0);
        while (!cmd_valid_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("update_latency", lat, 3);
        wait_cpl(1, 5000, "cfg_sweep_complete");
        @(negedge clk);
        check("cfg_ready_after", ready_o, 1);
        check("cfg_q_empty", q_cmd.size(), 0);
        check("cfg_cmd_count", cfg_acc, NUM_CFG);
        check("stall_consumed", stall_left, 0);

        // Idle with monitoring disabled: no commands at all.
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_valid_o || !ready_o) busy++;
        end
        check("rate0_idle", busy, 0);

        // Periodic monitor sweeps; update requests arrive mid-sweep.
        mon_rate_i = 16'd2;
        t = 0;
        while (mon_wr_total < NUM_MON + 10 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("mon_sweep_progress", mon_wr_total >= NUM_MON + 10, 1);
        push_cfg_sweep();
        pulse_update();
        repeat (5) @(negedge clk);
        pulse_update();
        wait_cpl(2, 5000, "mid_mon_cfg_complete");
        check("upd_after_mon_sweep", mon_wr_total, 2 * NUM_MON);
        mon_rate_i = 16'd0;
        wait_ready(2000, "mon_ready_after");
        repeat (20) @(negedge clk);
        check("single_cfg_sweep", cpl_cnt, 2);
        check("cfg_q_empty2", q_cmd.size(), 0);
        check("mon_whole_sweeps", mon_wr_total % NUM_MON, 0);
        check("mon_q_empty", q_mon.size(), 0);

        // Timeout on monitor index 3, then saturate the error counter.
        drop_idx   = 3;
        mon_rate_i = 16'd1;
        t = 0;
        while (!seen_drop && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("timeout_seen", seen_drop, 1);
        drop_idx = -1;
        inj_err  = 1'b1;
        t = 0;
        while (raw_err < 300 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("raw_err_reached", raw_err >= 300, 1);
        inj_err    = 1'b0;
        mon_rate_i = 16'd0;
        wait_ready(2000, "err_ready_after");
        check("err_saturated", err_count_o, 255);
        check("mon_q_empty2", q_mon.size(), 0);

        // Reset during CFG_WAIT at index 40, then restart.
        push_cfg_sweep();
        cfg40_hit = 1'b0;
        pulse_update();
        t = 0;
        while (!cfg40_hit && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reached_idx40", cfg40_hit, 1);
        cpl_before = cpl_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        exp_err = 0;
        repeat (20) @(negedge clk);
        check("no_cpl_after_reset", cpl_cnt, cpl_before);
        check("idle_after_reset", ready_o, 1);
        q_cmd.delete();
        cfg_acc = 0;
        push_cfg_sweep();
        pulse_update();
        wait_cpl(cpl_before + 1, 5000, "restart_complete");
        check("restart_q_empty", q_cmd.size(), 0);
        check("restart_cmd_count", cfg_acc, NUM_CFG);
        wait_ready(100, "restart_ready");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
